// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback stage: result-source encodings,
// load funct3 codes and the writeback FSM state type.
package riscv_wb_pkg;

  // wb_sel encodings
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_WAIT,
    S_COMMIT
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Bus between control/memory and the writeback unit.
//   master: control side, drives the request, operands and memory response.
//   slave : writeback unit, drives register-file write and status.
interface writeback_unit_if;
  logic        wb_start;
  logic [1:0]  wb_sel;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic        rd_write_en;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic [31:0] imm;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        wb_busy;
  logic        wb_done;
  logic        wb_err;

  modport master (
    output wb_start, wb_sel, funct3, rd_in, rd_write_en,
           alu_result, pc_plus4, imm, mem_rdata, mem_rvalid,
    input  reg_write, rd, write_data, wb_busy, wb_done, wb_err
  );

  modport slave (
    input  wb_start, wb_sel, funct3, rd_in, rd_write_en,
           alu_result, pc_plus4, imm, mem_rdata, mem_rvalid,
    output reg_write, rd, write_data, wb_busy, wb_done, wb_err
  );
endinterface

// File: rtl/writeback_unit_load_extender.sv
// Combinational load alignment and sign/zero extension.
//   funct3                : load type (LB, LH, LW, LBU, LHU)
//   addr                  : low two bits of the effective address
//   word                  : word-aligned memory data
//   data                  : aligned, extended result
//   misaligned_or_illegal : misaligned halfword/word or unsupported funct3
module load_extender
  import riscv_wb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned_or_illegal
);

  logic [31:0] lane_word;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    lane_word = word >> {addr, 3'b000};
    byte_val  = lane_word[7:0];
    half_val  = addr[1] ? word[31:16] : word[15:0];
    data      = '0;
    misaligned_or_illegal = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_val[7]}}, byte_val};
      F3_LBU: data = {24'h0, byte_val};
      F3_LH: begin
        data = {{16{half_val[15]}}, half_val};
        misaligned_or_illegal = addr[0];
      end
      F3_LHU: begin
        data = {16'h0, half_val};
        misaligned_or_illegal = addr[0];
      end
      F3_LW: begin
        data = word;
        misaligned_or_illegal = (addr != 2'b00);
      end
      default: misaligned_or_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: selects the result source, waits for load data, aligns
// and extends it, and issues a single-cycle register-file write.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : request/operands/memory response in; reg_write, rd,
//              write_data, wb_busy, wb_done, wb_err out (all registered)
module writeback_unit
  import riscv_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input logic            clk,
  input logic            rst,
  writeback_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  wb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             reg_write_q, reg_write_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [31:0]      ext_data;
  logic             ext_bad;

  load_extender u_ext (
    .funct3                (f3_q),
    .addr                  (addr_q),
    .word                  (bus.mem_rdata),
    .data                  (ext_data),
    .misaligned_or_illegal (ext_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Output values are computed one cycle ahead and registered so that the
  // COMMIT-cycle outputs come straight from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    data_d      = data_q;
    reg_write_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.wb_start) begin
          rd_d   = bus.rd_in;
          we_d   = bus.rd_write_en;
          f3_d   = bus.funct3;
          addr_d = bus.alu_result[1:0];
          if (bus.wb_sel == WB_MEM) begin
            state_d = S_MEM_WAIT;
            cnt_d   = '0;
          end else begin
            state_d     = S_COMMIT;
            reg_write_d = bus.rd_write_en && (bus.rd_in != '0);
            done_d      = 1'b1;
            case (bus.wb_sel)
              WB_PC4:  data_d = bus.pc_plus4;
              WB_IMM:  data_d = bus.imm;
              default: data_d = bus.alu_result;
            endcase
          end
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d     = S_COMMIT;
          done_d      = 1'b1;
          err_d       = ext_bad;
          reg_write_d = we_q && (rd_q != '0) && !ext_bad;
          if (!ext_bad) data_d = ext_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_COMMIT;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      reg_write_q <= reg_write_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.reg_write  = reg_write_q;
  assign bus.rd         = rd_q;
  assign bus.write_data = data_q;
  assign bus.wb_busy    = busy_q;
  assign bus.wb_done    = done_q;
  assign bus.wb_err     = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, reset
// mid-load sequence, and randomized transactions against a reference model.
module tb_writeback_unit;

  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  writeback_unit_if bus ();

  writeback_unit #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] word;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc4;
    logic [31:0] imm;
    int          delay;     // cycle after start carrying rvalid; >TIMEOUT: never
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_err;
  } vec_t;

  vec_t tbl [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model computed from the load/writeback rules directly.
  task automatic model(input vec_t v, output logic [31:0] d, output logic we, output logic err);
    logic [31:0] b, h;
    int a;
    a   = int'(v.alu[1:0]);
    b   = (v.word >> (8 * a)) & 32'hFF;
    h   = (v.word >> (16 * (a / 2))) & 32'hFFFF;
    d   = 32'h0;
    err = 1'b0;
    if (v.sel == 2'd0)      d = v.alu;
    else if (v.sel == 2'd2) d = v.pc4;
    else if (v.sel == 2'd3) d = v.imm;
    else if (v.delay < 1 || v.delay > TIMEOUT) err = 1'b1;
    else begin
      case (v.f3)
        3'd0: d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
        3'd4: d = b;
        3'd1: if (a % 2 != 0) err = 1'b1; else d = (h >= 32768) ? h + 32'hFFFF_0000 : h;
        3'd5: if (a % 2 != 0) err = 1'b1; else d = h;
        3'd2: if (a != 0) err = 1'b1; else d = v.word;
        default: err = 1'b1;
      endcase
    end
    we = v.we && (v.rd != 0) && !err;
  endtask

  task automatic run(input vec_t v, input logic [31:0] ed, input logic ewe, input logic eerr);
    bus.wb_start    = 1'b1;
    bus.wb_sel      = v.sel;
    bus.funct3      = v.f3;
    bus.rd_in       = v.rd;
    bus.rd_write_en = v.we;
    bus.alu_result  = v.alu;
    bus.pc_plus4    = v.pc4;
    bus.imm         = v.imm;
    bus.mem_rvalid  = 1'($urandom);   // ignored in IDLE
    bus.mem_rdata   = $urandom;
    step();
    bus.wb_start   = 1'b0;
    bus.mem_rvalid = 1'b0;
    if (v.sel == 2'd1) begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        chk("wait_busy", bus.wb_busy, 1);
        chk("wait_done", bus.wb_done, 0);
        chk("wait_reg_write", bus.reg_write, 0);
        // operand inputs wander while busy; only latched values may matter
        bus.wb_start   = 1'($urandom);
        bus.wb_sel     = 2'($urandom);
        bus.funct3     = 3'($urandom);
        bus.rd_in      = 5'($urandom);
        bus.alu_result = $urandom;
        bus.mem_rvalid = (k == v.delay);
        bus.mem_rdata  = (k == v.delay) ? v.word : $urandom;
        step();
        if (k == v.delay) break;
      end
      bus.wb_start   = 1'b0;
      bus.mem_rvalid = 1'b0;
    end
    chk("commit_reg_write", bus.reg_write, ewe);
    chk("commit_rd", bus.rd, v.rd);
    chk("commit_done", bus.wb_done, 1);
    chk("commit_err", bus.wb_err, eerr);
    chk("commit_busy", bus.wb_busy, 1);
    if (!eerr) chk("commit_data", bus.write_data, ed);
    step();
    chk("post_done", bus.wb_done, 0);
    chk("post_reg_write", bus.reg_write, 0);
    chk("post_err", bus.wb_err, 0);
    chk("post_busy", bus.wb_busy, 0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] md;
    logic mwe, merr;
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.wb_start = 0; bus.wb_sel = 0; bus.funct3 = 0; bus.rd_in = 0;
    bus.rd_write_en = 0; bus.alu_result = 0; bus.pc_plus4 = 0; bus.imm = 0;
    bus.mem_rdata = 0; bus.mem_rvalid = 0;

    //           sel   f3    alu            word           rd     we    pc4         imm           dly exp_data       we    err
    tbl[0]  = '{2'd0, 3'd0, 32'h0000_1234, 32'h0,         5'd5,  1'b1, 32'h0,      32'h0,         0, 32'h0000_1234, 1'b1, 1'b0};
    tbl[1]  = '{2'd1, 3'd0, 32'h0000_1002, 32'h1180_FF22, 5'd6,  1'b1, 32'h0,      32'h0,         2, 32'hFFFF_FF80, 1'b1, 1'b0};
    tbl[2]  = '{2'd1, 3'd5, 32'h0000_2002, 32'h8001_0000, 5'd7,  1'b1, 32'h0,      32'h0,         1, 32'h0000_8001, 1'b1, 1'b0};
    tbl[3]  = '{2'd1, 3'd2, 32'h0000_3001, 32'h1234_5678, 5'd8,  1'b1, 32'h0,      32'h0,         1, 32'h0,         1'b0, 1'b1};
    tbl[4]  = '{2'd1, 3'd2, 32'h0000_0100, 32'h0,         5'd9,  1'b1, 32'h0,      32'h0,        99, 32'h0,         1'b0, 1'b1};
    tbl[5]  = '{2'd2, 3'd0, 32'h0,         32'h0,         5'd0,  1'b1, 32'h104,    32'h0,         0, 32'h0000_0104, 1'b0, 1'b0};
    tbl[6]  = '{2'd3, 3'd0, 32'h0,         32'h0,         5'd31, 1'b1, 32'h0,      32'hABCD_E000, 0, 32'hABCD_E000, 1'b1, 1'b0};
    tbl[7]  = '{2'd1, 3'd1, 32'h0000_0002, 32'h8001_0000, 5'd10, 1'b1, 32'h0,      32'h0,         3, 32'hFFFF_8001, 1'b1, 1'b0};
    tbl[8]  = '{2'd1, 3'd4, 32'h0000_0003, 32'hA500_0000, 5'd11, 1'b1, 32'h0,      32'h0,         5, 32'h0000_00A5, 1'b1, 1'b0};
    tbl[9]  = '{2'd1, 3'd3, 32'h0000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'h0,      32'h0,         1, 32'h0,         1'b0, 1'b1};
    tbl[10] = '{2'd0, 3'd0, 32'hCAFE_F00D, 32'h0,         5'd13, 1'b0, 32'h0,      32'h0,         0, 32'hCAFE_F00D, 1'b0, 1'b0};
    tbl[11] = '{2'd1, 3'd2, 32'h0000_0040, 32'hDEAD_BEEF, 5'd14, 1'b1, 32'h0,      32'h0,        16, 32'hDEAD_BEEF, 1'b1, 1'b0};
    tbl[12] = '{2'd1, 3'd1, 32'h0000_0001, 32'h1234_5678, 5'd15, 1'b1, 32'h0,      32'h0,         1, 32'h0,         1'b0, 1'b1};

    // Reset state
    step();
    step();
    chk("rst_reg_write", bus.reg_write, 0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_busy", bus.wb_busy, 0);
    chk("rst_done", bus.wb_done, 0);
    chk("rst_err", bus.wb_err, 0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) run(tbl[i], tbl[i].exp_data, tbl[i].exp_we, tbl[i].exp_err);

    // Reset mid-load, then late rvalid must be ignored
    bus.wb_start = 1'b1; bus.wb_sel = 2'd1; bus.funct3 = 3'd2; bus.rd_in = 5'd9;
    bus.rd_write_en = 1'b1; bus.alu_result = 32'h0;
    step();
    bus.wb_start = 1'b0;
    step();
    step();
    chk("midrst_busy_before", bus.wb_busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.wb_busy, 0);
    chk("midrst_reg_write", bus.reg_write, 0);
    chk("midrst_done", bus.wb_done, 0);
    chk("midrst_rd", bus.rd, 0);
    step();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    step();
    bus.mem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("late_rvalid_reg_write", bus.reg_write, 0);
      chk("late_rvalid_done", bus.wb_done, 0);
      chk("late_rvalid_busy", bus.wb_busy, 0);
      step();
    end
    run(tbl[0], tbl[0].exp_data, tbl[0].exp_we, tbl[0].exp_err);

    // Randomized transactions against the model
    for (int n = 0; n < 200; n++) begin
      v.sel   = 2'($urandom);
      v.f3    = 3'($urandom);
      v.alu   = $urandom;
      v.word  = $urandom;
      v.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      v.we    = ($urandom_range(0, 5) != 0);
      v.pc4   = $urandom;
      v.imm   = $urandom;
      v.delay = $urandom_range(1, 20);
      v.exp_data = 32'h0; v.exp_we = 1'b0; v.exp_err = 1'b0;
      model(v, md, mwe, merr);
      run(v, md, mwe, merr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
